max_unpooling_unit: RTL and testbench

Inverse of the max pooling stage. Scans each serial input window of SIZE signed elements, records the argmax position, and queues it in an index FIFO. Later it accepts the pooled (or back-propagated) value for that window and re-expands it into SIZE serial output elements: the value at the recorded argmax position, zero at every other position. Sits after the pooling stage's input tap and before the upsampling/decoder layers.

---
 rtl/max_unpooling_unit.sv | 191 +++++++++++++++++++
 tb/tb_max_unpooling_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpooling_unit.sv
// max_unpooling_unit: inverse of a max-pooling stage.
// Capture side scans serial windows of SIZE signed elements, tracks the argmax
// position (ties resolve to the highest position) and queues it in an index FIFO.
// Expand side takes one pooled value per queued window and emits SIZE serial
// elements: the pooled value at the recorded argmax position, zero elsewhere.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data       window element stream, position 0 first
//   pool_valid/pool_ready/pool_data pooled value for the oldest queued window
//   out_valid/out_ready/out_data    expanded element stream
//   out_last                        marks position SIZE-1 of each window
// Optional feature (macro MAX_UNPOOL_OCCUPANCY_EN):
//   idx_count    registered FIFO occupancy
//   ovf_blocked  sticky flag, set when in_valid is presented while in_ready=0
module max_unpooling_unit #(
  parameter int SIZE    = 4,
  parameter int I_WIDTH = 16,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [I_WIDTH-1:0] in_data,
  input  logic                      pool_valid,
  output logic                      pool_ready,
  input  logic signed [I_WIDTH-1:0] pool_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [I_WIDTH-1:0] out_data,
  output logic                      out_last
`ifdef MAX_UNPOOL_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] idx_count,
  output logic                       ovf_blocked
`endif
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(SIZE-1);
  localparam logic [CNT_W-1:0] FULL_OCC = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                      state_r;
  logic [IDX_W-1:0]            ecnt_r;
  logic [IDX_W-1:0]            arg_r;
  logic signed [I_WIDTH-1:0]   max_r;
  logic [IDX_W-1:0]            mem_r [DEPTH];
  logic [PTR_W-1:0]            wptr_r;
  logic [PTR_W-1:0]            rptr_r;
  logic [CNT_W-1:0]            occ_r;
  logic [IDX_W-1:0]            ocnt_r;
  logic [IDX_W-1:0]            tgt_r;
  logic signed [I_WIDTH-1:0]   val_r;

  logic                        in_hs_s;
  logic                        push_s;
  logic                        pop_s;
  logic [IDX_W-1:0]            arg_next_s;
  logic signed [I_WIDTH-1:0]   max_next_s;
  logic [IDX_W-1:0]            ocnt_inc_s;
  logic [IDX_W-1:0]            head_s;

  // Handshakes, ready flags and the running argmax including the current element.
  always_comb begin
    // Readies depend on registered state only; a same-cycle pop cannot unblock capture.
    in_ready   = !((ecnt_r == LAST_POS) && (occ_r == FULL_OCC));
    pool_ready = (state_r == IDLE) && (occ_r != {CNT_W{1'b0}});
    in_hs_s    = in_valid && in_ready;
    push_s     = in_hs_s && (ecnt_r == LAST_POS);
    pop_s      = pool_valid && pool_ready;
    head_s     = mem_r[rptr_r];
    ocnt_inc_s = ocnt_r + IDX_W'(1);
    if (ecnt_r == {IDX_W{1'b0}}) begin
      arg_next_s = {IDX_W{1'b0}};
      max_next_s = in_data;
    end else if (in_data >= max_r) begin
      // >= makes ties move to the later position
      arg_next_s = ecnt_r;
      max_next_s = in_data;
    end else begin
      arg_next_s = arg_r;
      max_next_s = max_r;
    end
  end

  // Capture side: element counter and running max/argmax.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_r <= {IDX_W{1'b0}};
      arg_r  <= {IDX_W{1'b0}};
      max_r  <= {I_WIDTH{1'b0}};
    end else if (in_hs_s) begin
      arg_r  <= arg_next_s;
      max_r  <= max_next_s;
      ecnt_r <= (ecnt_r == LAST_POS) ? {IDX_W{1'b0}} : (ecnt_r + IDX_W'(1));
    end
  end

  // Index FIFO: storage, wrapping pointers and registered occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {IDX_W{1'b0}};
      end
      wptr_r <= {PTR_W{1'b0}};
      rptr_r <= {PTR_W{1'b0}};
      occ_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= arg_next_s;
        wptr_r        <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Expand FSM with registered output beat; the next beat is precomputed on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ocnt_r    <= {IDX_W{1'b0}};
      tgt_r     <= {IDX_W{1'b0}};
      val_r     <= {I_WIDTH{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {I_WIDTH{1'b0}};
      out_last  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            val_r     <= pool_data;
            tgt_r     <= head_s;
            ocnt_r    <= {IDX_W{1'b0}};
            out_valid <= 1'b1;
            out_data  <= (head_s == {IDX_W{1'b0}}) ? pool_data : {I_WIDTH{1'b0}};
            out_last  <= 1'b0;  // SIZE >= 2, so position 0 is never last
            state_r   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (ocnt_r == LAST_POS) begin
              out_valid <= 1'b0;
              out_data  <= {I_WIDTH{1'b0}};
              out_last  <= 1'b0;
              state_r   <= IDLE;
            end else begin
              ocnt_r   <= ocnt_inc_s;
              out_data <= (ocnt_inc_s == tgt_r) ? val_r : {I_WIDTH{1'b0}};
              out_last <= (ocnt_inc_s == LAST_POS);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_data  <= {I_WIDTH{1'b0}};
          out_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAX_UNPOOL_OCCUPANCY_EN
  // Occupancy is exported directly from the registered counter.
  always_comb begin
    idx_count = occ_r;
  end

  // Sticky record of any capture stall seen since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_blocked <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf_blocked <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_max_unpooling_unit.sv
module tb_max_unpooling_unit;
  localparam int SIZE = 4;
  localparam int IW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [IW-1:0] in_data = '0;
  logic pool_valid = 1'b0;
  logic pool_ready;
  logic signed [IW-1:0] pool_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [IW-1:0] out_data;
  logic out_last;
`ifdef MAX_UNPOOL_OCCUPANCY_EN
  logic [$clog2(DEPTH+1)-1:0] idx_count;
  logic ovf_blocked;
`endif

  max_unpooling_unit #(.SIZE(SIZE), .I_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pool_valid(pool_valid), .pool_ready(pool_ready), .pool_data(pool_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef MAX_UNPOOL_OCCUPANCY_EN
    , .idx_count(idx_count), .ovf_blocked(ovf_blocked)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // behavioural model state
  int mwin[$];
  int mq[$];
  int bd[$];
  bit bl[$];
  // observations
  int obs[$];
  bit obs_last[$];
  int pool_hs_cyc = -1;
  int in_hs_cyc = -1;
  int first_ov_cyc = -1;
  bit ov_seen = 1'b0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  int prev_d = 0;
  bit prev_l = 1'b0;
  bit bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver: always 1 unless the backpressure pattern is enabled
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_en ? bp_pat[cyc % 4] : 1'b1;
  end

  // compare process: model vs DUT every cycle, sampled at the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_pool_ready", pool_ready, 0);
      chk("rst_in_ready", in_ready, 1);
      mwin.delete(); mq.delete(); bd.delete(); bl.delete();
      prev_stall = 1'b0;
    end else begin
      bit exp_ir, exp_pr, exp_ov;
      exp_ir = !((mwin.size() == SIZE-1) && (mq.size() == DEPTH));
      exp_pr = (bd.size() == 0) && (mq.size() > 0);
      exp_ov = (bd.size() > 0);
      chk("in_ready", in_ready, exp_ir);
      chk("pool_ready", pool_ready, exp_pr);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_data", $signed(out_data), bd[0]);
        chk("out_last", out_last, bl[0]);
      end
      if (prev_stall && out_valid) begin
        chk("stall_data_stable", $signed(out_data), prev_d);
        chk("stall_last_stable", out_last, prev_l);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      if (prev_stall) stall_cnt++;
      if (out_valid && !ov_seen) begin ov_seen = 1'b1; first_ov_cyc = cyc; end
      if (out_valid && out_ready) begin obs.push_back(out_data); obs_last.push_back(out_last); end
      if (pool_valid && pool_ready) pool_hs_cyc = cyc;
      if (in_valid && in_ready) in_hs_cyc = cyc;
      // model update, driven by the model's own readies
      if (exp_ov && out_ready) begin void'(bd.pop_front()); void'(bl.pop_front()); end
      if (pool_valid && exp_pr) begin
        int tgt;
        tgt = mq.pop_front();
        for (int i = 0; i < SIZE; i++) begin
          bd.push_back((i == tgt) ? int'(pool_data) : 0);
          bl.push_back(i == SIZE-1);
        end
      end
      if (in_valid && exp_ir) begin
        mwin.push_back(in_data);
        if (mwin.size() == SIZE) begin
          int best, a;
          best = mwin[0]; a = 0;
          for (int i = 1; i < SIZE; i++) begin
            if (mwin[i] >= best) begin best = mwin[i]; a = i; end
          end
          mq.push_back(a);
          mwin.delete();
        end
      end
    end
  end

  task automatic send(input int d);
    bit hs;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = IW'(d);
    forever begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 100) begin chk("send_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_win(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic pool(input int d);
    bit hs;
    int n;
    n = 0;
    pool_valid = 1'b1;
    pool_data = IW'(d);
    forever begin
      @(negedge clk);
      hs = pool_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 100) begin chk("pool_timeout", 0, 1); break; end
    end
    pool_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int k;
    k = 0;
    while (obs.size() < n) begin
      @(posedge clk);
      #1;
      k++;
      if (k > 300) begin chk("obs_timeout", obs.size(), n); break; end
    end
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_last.delete();
    ov_seen = 1'b0;
  endtask

  task automatic check_beats(input string nm, input int off, input int e0, input int e1,
                             input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    if (obs.size() < off + 4) begin
      chk({nm, "_count"}, obs.size(), off + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk({nm, "_data"}, obs[off+i], e[i]);
        chk({nm, "_last"}, obs_last[off+i], (i == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_pool_ready", pool_ready, 0);

    // basic window and latency
    send_win(3, -7, 12, 5);
    clear_obs();
    pool(99);
    wait_obs(4);
    check_beats("basic", 0, 0, 0, 99, 0);
    chk("latency", first_ov_cyc - pool_hs_cyc, 1);

    // tie goes to highest position; all-negative window
    send_win(8, 2, 8, -1);
    clear_obs();
    pool(5);
    wait_obs(4);
    check_beats("tie", 0, 0, 0, 5, 0);
    send_win(-4, -9, -2, -3);
    clear_obs();
    pool(-2);
    wait_obs(4);
    check_beats("negative", 0, 0, 0, -2, 0);

    // fill the FIFO, 5th window's last element stalls until one pop
    send_win(1, 2, 3, 4);
    send_win(9, 0, 0, 0);
    send_win(0, 5, 0, 0);
    send_win(0, 0, 6, 0);
    send(1); send(1); send(1);
    in_valid = 1'b1;
    in_data = 16'sd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("full_in_ready", in_ready, 0);
    end
    clear_obs();
    in_hs_cyc = -1;
    pool_valid = 1'b1;
    pool_data = 16'sd11;
    for (int i = 0; i < 30 && in_valid; i++) begin
      @(posedge clk);
      #1;
      if (pool_hs_cyc == cyc - 1) pool_valid = 1'b0;
      if (in_hs_cyc == cyc - 1) in_valid = 1'b0;
    end
    pool_valid = 1'b0;
    chk("unblock_delay", in_hs_cyc - pool_hs_cyc, 1);
    in_valid = 1'b0;
    pool(12); pool(13); pool(14); pool(15);
    wait_obs(20);
    check_beats("fill_w1", 0, 0, 0, 0, 11);
    check_beats("fill_w2", 4, 12, 0, 0, 0);
    check_beats("fill_w3", 8, 0, 13, 0, 0);
    check_beats("fill_w4", 12, 0, 0, 14, 0);
    check_beats("fill_w5", 16, 0, 0, 0, 15);

    // pool_valid with empty FIFO is held off
    pool_valid = 1'b1;
    pool_data = 16'sd42;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("empty_pool_ready", pool_ready, 0);
    end
    @(posedge clk);
    #1;
    clear_obs();
    send_win(2, 1, 0, -1);
    chk("pool_ready_after_window", pool_ready, 1);
    @(posedge clk);
    #1;
    pool_valid = 1'b0;
    wait_obs(4);
    check_beats("empty_then_window", 0, 42, 0, 0, 0);

    // backpressure on the output side
    bp_en = 1'b1;
    send_win(0, 10, -3, 4);
    clear_obs();
    stall_cnt = 0;
    pool(77);
    wait_obs(4);
    bp_en = 1'b0;
    check_beats("backpressure", 0, 0, 77, 0, 0);
    chk("backpressure_stalled", (stall_cnt > 0) ? 1 : 0, 1);

    // reset mid-EMIT (ocnt=2) and mid-capture (ecnt=1)
    send_win(3, 1, 2, 0);
    send(9);
    clear_obs();
    pool(50);
    wait_obs(2);
    chk("pre_reset_beat0", obs[0], 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_win(1, 2, 3, 4);
    clear_obs();
    pool(7);
    wait_obs(4);
    check_beats("after_reset", 0, 0, 0, 0, 7);
    chk("after_reset_beats", obs.size(), 4);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
